// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-interface stage: size and state encodings,
// default widths and byte-count helpers.
package mem_if_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 9;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of bytes moved for a given size; reserved size moves none.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: byte_count = 3'd1;
      SIZE_HALF: byte_count = 3'd2;
      SIZE_WORD: byte_count = 3'd4;
      default:   byte_count = 3'd0;
    endcase
  endfunction

  // Index of the final byte (n-1); doubles as the alignment mask.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    return 2'(byte_count(size) - 3'd1);
  endfunction

endpackage

// File: rtl/read_data_formatter.sv
// Turns the right-justified read shift register into a full-width word,
// sign- or zero-extending byte and halfword reads.
module read_data_formatter
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] i_shift,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_data
);

  // Extend from the top bit of the assembled field.
  always_comb begin
    o_data = i_shift;
    unique case (i_size)
      SIZE_BYTE: o_data = {{(DATA_W-8){i_sign & i_shift[7]}}, i_shift[7:0]};
      SIZE_HALF: o_data = {{(DATA_W-16){i_sign & i_shift[15]}}, i_shift[15:0]};
      default:   o_data = i_shift;
    endcase
  end

endmodule

// File: rtl/ram_access_controller.sv
// Converts a MFA/MOC memory request into big-endian byte accesses on a
// byte-wide RAM with combinational read, one byte per cycle.
module ram_access_controller
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              moc,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  state_e            r_state, w_state_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_sign, w_sign_nxt;
  logic [1:0]        r_size, w_size_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_err, w_err_nxt;
  logic              r_moc, w_moc_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [7:0]        r_ram_wdata, w_ram_wdata_nxt;
  logic              r_ram_we, w_ram_we_nxt;

  logic [1:0]        w_last_req;
  logic [1:0]        w_last;
  logic [1:0]        w_next_sel;
  logic              w_bad;
  logic [7:0]        w_wbyte_first;
  logic [7:0]        w_wbyte_next;
  logic [DATA_W-1:0] w_fmt;

  // Request decode on the live inputs (only consumed in IDLE).
  assign w_last_req    = last_index(size);
  assign w_bad         = (size == SIZE_RSVD) || ((address[1:0] & w_last_req) != 2'b00);
  assign w_wbyte_first = data_in[{w_last_req, 3'b000} +: 8];

  // Big-endian: byte i of the transfer is data byte (n-1-i); next one is n-2-i.
  assign w_last       = last_index(r_size);
  assign w_next_sel   = w_last - r_idx - 2'd1;
  assign w_wbyte_next = r_wdata[{w_next_sel, 3'b000} +: 8];

  read_data_formatter #(
    .DATA_W (DATA_W)
  ) u_fmt (
    .i_shift (r_shift),
    .i_size  (r_size),
    .i_sign  (r_sign),
    .o_data  (w_fmt)
  );

  // State and registered-output update with synchronous reset.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rw        <= 1'b0;
      r_sign      <= 1'b0;
      r_size      <= 2'b00;
      r_wdata     <= '0;
      r_idx       <= 2'd0;
      r_shift     <= '0;
      r_err       <= 1'b0;
      r_moc       <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 8'h00;
      r_ram_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rw        <= w_rw_nxt;
      r_sign      <= w_sign_nxt;
      r_size      <= w_size_nxt;
      r_wdata     <= w_wdata_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_err       <= w_err_nxt;
      r_moc       <= w_moc_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ram_we    <= w_ram_we_nxt;
    end
  end

  // Next-state logic; RAM bus values are set up one cycle ahead so they are registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_rw_nxt        = r_rw;
    w_sign_nxt      = r_sign;
    w_size_nxt      = r_size;
    w_wdata_nxt     = r_wdata;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_err_nxt       = r_err;
    w_moc_nxt       = r_moc;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ram_we_nxt    = r_ram_we;

    unique case (r_state)
      IDLE: begin
        if (mfa) begin
          w_rw_nxt    = rw;
          w_sign_nxt  = sign;
          w_size_nxt  = size;
          w_wdata_nxt = data_in;
          w_idx_nxt   = 2'd0;
          w_shift_nxt = '0;
          if (w_bad) begin
            w_state_nxt = DONE;
            w_err_nxt   = 1'b1;
            w_moc_nxt   = 1'b1;
          end else begin
            w_state_nxt    = XFER;
            w_err_nxt      = 1'b0;
            w_ram_addr_nxt = address;
            w_ram_we_nxt   = ~rw;
            if (!rw) w_ram_wdata_nxt = w_wbyte_first;
          end
        end
      end
      XFER: begin
        if (r_rw) w_shift_nxt = {r_shift[DATA_W-9:0], ram_rdata};
        if (r_idx == w_last) begin
          w_state_nxt  = DONE;
          w_moc_nxt    = 1'b1;
          w_ram_we_nxt = 1'b0;
        end else begin
          w_idx_nxt      = r_idx + 2'd1;
          w_ram_addr_nxt = r_ram_addr + ADDR_W'(1);
          if (!r_rw) w_ram_wdata_nxt = w_wbyte_next;
        end
      end
      DONE: begin
        if (!mfa) begin
          w_state_nxt = IDLE;
          w_moc_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_moc_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_ram_we_nxt = 1'b0;
      end
    endcase
  end

  // Read data is only presented for successful reads while complete.
  assign data_out  = (r_state == DONE && r_rw && !r_err) ? w_fmt : '0;
  assign moc       = r_moc;
  assign err       = r_err;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;

endmodule
